// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings, ALU ops,
// mux select codes, opcode/funct constants and the control-word struct.
package mc_ctrl_defs;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_LD_WB    = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_alu_op_decode.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported codes.
module alu_op_decode
  import mc_ctrl_defs::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit: sequences the single-ALU datapath one instruction at a time.
module mc_ctrl_fsm
  import mc_ctrl_defs::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t     state, state_next;
  ctrl_t      c;
  logic [2:0] dec_alu_op;
  logic       dec_illegal;
  logic       unused_zero;

  // Branch qualification by zero happens in the datapath.
  assign unused_zero = zero;

  alu_op_decode u_alu_op_decode (
    .funct   (funct),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_EXEC_R;
          OP_ADDI:      state_next = S_EXEC_I;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        if (dec_illegal) state_next = S_ILLEGAL;
        else             state_next = S_R_WB;
      end
      S_EXEC_I:   state_next = S_I_WB;
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_next = S_MEM_RD;
        else if (opcode == OP_SW) state_next = S_MEM_WR;
        else                      state_next = S_FETCH;
      end
      S_MEM_RD:   if (mem_ready) state_next = S_LD_WB;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
      S_R_WB, S_I_WB, S_LD_WB, S_BRANCH, S_JUMP, S_ILLEGAL: state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Control word from state; FETCH's IR/PC strobes are qualified by mem_ready.
  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = dec_alu_op;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_I_WB:     c.reg_write = 1'b1;
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_LD_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_ILLEGAL:  c.illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign alu_op        = c.alu_op;
  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.pc_write_cond;
  assign pc_source     = c.pc_source;
  assign iord          = c.iord;
  assign mem_read      = c.mem_read;
  assign mem_write     = c.mem_write;
  assign ir_write      = c.ir_write;
  assign reg_write     = c.reg_write;
  assign reg_dst       = c.reg_dst;
  assign mem_to_reg    = c.mem_to_reg;
  assign illegal_op    = c.illegal_op;
  assign state_o       = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: each instruction is expanded into an expected per-cycle
// control trace, which is then replayed against the DUT.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       alu_src_a, pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state_o(state_o)
  );

  typedef struct packed {
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] op;
    logic       pcw, pcwc;
    logic [1:0] pcs;
    logic       iord, mr, mw, irw, rw, rdst, m2r, ill;
  } exp_t;

  exp_t obs;
  assign obs = {alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_source,
                iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op};

  exp_t  exp_q[$];
  logic  rdy_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t fetch_c(logic done);
    exp_t c = '0;
    c.mr = 1'b1; c.src_b = 2'b01;
    c.irw = done; c.pcw = done;
    return c;
  endfunction

  task automatic push(exp_t c, logic r, string t);
    exp_q.push_back(c); rdy_q.push_back(r); tag_q.push_back(t);
  endtask

  // Reference trace: one entry per clock, built straight from the instruction semantics.
  task automatic plan(logic [5:0] op, logic [5:0] fn, int fw, int mw);
    exp_t c;
    logic [2:0] aop;
    bit fn_ok;
    for (int i = 0; i < fw; i++) push(fetch_c(1'b0), 1'b0, "fetch_wait");
    push(fetch_c(1'b1), 1'b1, "fetch");
    c = '0; c.src_b = 2'b11; push(c, rb(), "decode");
    case (op)
      6'h00: begin
        fn_ok = 1'b1;
        case (fn)
          6'h20: aop = 3'd0;
          6'h22: aop = 3'd1;
          6'h24: aop = 3'd2;
          6'h25: aop = 3'd3;
          6'h2A: aop = 3'd4;
          default: begin aop = 3'd0; fn_ok = 1'b0; end
        endcase
        c = '0; c.src_a = 1'b1; c.op = aop; push(c, rb(), "exec_r");
        c = '0;
        if (fn_ok) begin c.rw = 1'b1; c.rdst = 1'b1; push(c, rb(), "r_wb"); end
        else begin c.ill = 1'b1; push(c, rb(), "illegal_funct"); end
      end
      6'h08: begin
        c = '0; c.src_a = 1'b1; c.src_b = 2'b10; push(c, rb(), "exec_i");
        c = '0; c.rw = 1'b1; push(c, rb(), "i_wb");
      end
      6'h23, 6'h2B: begin
        c = '0; c.src_a = 1'b1; c.src_b = 2'b10; push(c, rb(), "mem_addr");
        c = '0; c.iord = 1'b1;
        if (op == 6'h23) c.mr = 1'b1; else c.mw = 1'b1;
        for (int i = 0; i < mw; i++) push(c, 1'b0, "mem_wait");
        push(c, 1'b1, "mem_done");
        if (op == 6'h23) begin
          c = '0; c.rw = 1'b1; c.m2r = 1'b1; push(c, rb(), "ld_wb");
        end
      end
      6'h04: begin
        c = '0; c.src_a = 1'b1; c.op = 3'd1; c.pcwc = 1'b1; c.pcs = 2'b01;
        push(c, rb(), "branch");
      end
      6'h02: begin
        c = '0; c.pcw = 1'b1; c.pcs = 2'b10; push(c, rb(), "jump");
      end
      default: begin
        c = '0; c.ill = 1'b1; push(c, rb(), "illegal_op");
      end
    endcase
  endtask

  task automatic step();
    exp_t  e = exp_q.pop_front();
    logic  r = rdy_q.pop_front();
    string t = tag_q.pop_front();
    logic  in_fetch = (t == "fetch" || t == "fetch_wait");
    mem_ready = r;
    zero = rb();
    @(negedge clk);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
    checks++;
    assert ((state_o === 4'd0) === in_fetch) else begin
      failures++;
      $error("FAIL %s_state observed=%0d expected_fetch=%0b", t, state_o, in_fetch);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int fw, int mw);
    opcode = op; funct = fn;
    plan(op, fn, fw, mw);
    while (exp_q.size() > 0) step();
  endtask

  initial begin
    logic [5:0] legal_fn [5];
    logic [5:0] op, fn;
    legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    reset_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    #1;
    checks++;
    assert (state_o === 4'd0 && obs === fetch_c(1'b0)) else begin
      failures++;
      $error("FAIL reset observed=%0d/%h expected=0/%h", state_o, obs, fetch_c(1'b0));
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed cases
    run_instr(6'h00, 6'h20, 0, 0);
    run_instr(6'h23, 6'h00, 0, 3);
    run_instr(6'h04, 6'h00, 0, 0);
    run_instr(6'h02, 6'h00, 0, 0);
    run_instr(6'h3F, 6'h20, 0, 0);
    run_instr(6'h00, 6'h00, 0, 0);
    run_instr(6'h2B, 6'h00, 2, 2);
    run_instr(6'h08, 6'h00, 1, 0);

    // Abandon a load mid-MEM_RD with an asynchronous reset
    opcode = 6'h23; funct = 6'h00;
    plan(6'h23, 6'h00, 0, 3);
    repeat (4) step();
    mem_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    assert (state_o === 4'd0 && obs === fetch_c(1'b0)) else begin
      failures++;
      $error("FAIL async_reset observed=%0d/%h expected=0/%h", state_o, obs, fetch_c(1'b0));
    end
    exp_q.delete(); rdy_q.delete(); tag_q.delete();
    @(posedge clk); #1;
    checks++;
    assert (state_o === 4'd0 && mem_write === 1'b0 && reg_write === 1'b0) else begin
      failures++;
      $error("FAIL held_reset observed=%0d/%b%b expected=0/00", state_o, mem_write, reg_write);
    end
    reset_n = 1'b1;
    run_instr(6'h00, 6'h22, 0, 0);

    // Randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      fn = legal_fn[$urandom_range(0, 4)];
      case ($urandom_range(0, 7))
        0: op = 6'h00;
        1: begin op = 6'h00; fn = 6'($urandom_range(0, 63)); end
        2: op = 6'h08;
        3: op = 6'h23;
        4: op = 6'h2B;
        5: op = 6'h04;
        6: op = 6'h02;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
